// File: rtl/ovp_pkg.sv
// ovp_pkg: shared state encoding and constants for the 1010 stimulus transmitter.
package ovp_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;
    localparam logic [3:0] PAT_1010 = 4'b1010;
    localparam int         GAP_W    = 4;
endpackage

// File: rtl/ovp_tx_ctr.sv
// ovp_tx_ctr: loadable down-counter with zero flag; load wins over decrement.
module ovp_tx_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_dec && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end
    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/ovp_1010_tx.sv
// ovp_1010_tx: serial "10"x(N+1) burst plus zero gap, with golden 1010 hit strobe.
// Optional OVP_TX_STATUS_EN adds o_sent_cnt, a saturating count of hit strobes.
module ovp_1010_tx
    import ovp_pkg::*;
#(
    parameter int CW      = 8,
    parameter int GAP_LEN = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [CW-1:0] i_cnt_in,
    output logic          o_ready,
    output logic          o_busy,
    output logic          o_bit_out,
    output logic          o_bit_vld,
    output logic          o_exp_det,
    output logic          o_done
`ifdef OVP_TX_STATUS_EN
    ,
    output logic [15:0]   o_sent_cnt
`endif
);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_LEN - 1);

    state_t r_state, w_state_nxt;
    logic   r_ready, r_busy, r_bit_out, r_bit_vld, r_exp_det, r_done;
    logic   [2:0] r_hist;
    logic   [2:0] w_hist_src;
    logic   w_bit_nxt, w_vld_nxt, w_done_nxt, w_exp_nxt;
    logic   w_bit_load, w_bit_dec, w_bit_zero;
    logic   w_gap_load, w_gap_dec, w_gap_zero;

    // Bit counter holds the number of bits still to send after the current one.
    ovp_tx_ctr #(.W(CW + 1)) u_bit_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_bit_load),
        .i_val  ({i_cnt_in, 1'b1}),
        .i_dec  (w_bit_dec),
        .o_zero (w_bit_zero)
    );

    ovp_tx_ctr #(.W(GAP_W)) u_gap_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_gap_load),
        .i_val  (GAP_LOAD),
        .i_dec  (w_gap_dec),
        .o_zero (w_gap_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = 1'b0;
        w_vld_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_bit_load  = 1'b0;
        w_bit_dec   = 1'b0;
        w_gap_load  = 1'b0;
        w_gap_dec   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start && r_ready) begin
                    if (i_cnt_in != '0) begin
                        w_state_nxt = SEND;
                        w_bit_load  = 1'b1;
                        w_bit_nxt   = 1'b1;
                        w_vld_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            SEND: begin
                w_vld_nxt = 1'b1;
                if (w_bit_zero) begin
                    w_state_nxt = GAP;
                    w_gap_load  = 1'b1;
                end else begin
                    w_bit_dec = 1'b1;
                    w_bit_nxt = ~r_bit_out;
                end
            end
            GAP: begin
                if (w_gap_zero) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_gap_dec = 1'b1;
                    w_vld_nxt = 1'b1;
                end
            end
            DONE: w_state_nxt = IDLE;
        endcase
    end

    // History restarts with each burst so the strobe never spans two bursts.
    assign w_hist_src = (r_state == SEND) ? r_hist : 3'b000;
    assign w_exp_nxt  = (w_state_nxt == SEND) && ({w_hist_src, w_bit_nxt} == PAT_1010);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_bit_out <= 1'b0;
            r_bit_vld <= 1'b0;
            r_exp_det <= 1'b0;
            r_done    <= 1'b0;
            r_hist    <= 3'b000;
        end else begin
            r_state   <= w_state_nxt;
            r_ready   <= (w_state_nxt == IDLE);
            r_busy    <= (w_state_nxt == SEND) || (w_state_nxt == GAP);
            r_bit_out <= w_bit_nxt;
            r_bit_vld <= w_vld_nxt;
            r_exp_det <= w_exp_nxt;
            r_done    <= w_done_nxt;
            r_hist    <= {w_hist_src[1:0], w_bit_nxt};
        end
    end

    assign o_ready   = r_ready;
    assign o_busy    = r_busy;
    assign o_bit_out = r_bit_out;
    assign o_bit_vld = r_bit_vld;
    assign o_exp_det = r_exp_det;
    assign o_done    = r_done;

`ifdef OVP_TX_STATUS_EN
    logic [15:0] r_sent_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            r_sent_cnt <= '0;
        else if (r_exp_det && r_sent_cnt != 16'hFFFF)
            r_sent_cnt <= r_sent_cnt + 16'd1;
    end
    assign o_sent_cnt = r_sent_cnt;
`endif
endmodule

// File: tb/tb_ovp_1010_tx.sv
// tb_ovp_1010_tx: scoreboard bench for ovp_1010_tx with directed bursts.
module tb_ovp_1010_tx;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_cnt_in = '0;
    logic       o_ready, o_busy, o_bit_out, o_bit_vld, o_exp_det, o_done;
`ifdef OVP_TX_STATUS_EN
    logic [15:0] o_sent_cnt;
`endif

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         det_total = 0;
    logic [2:0] hist = 3'b000;
    logic [1:0] exp_q[$];
    int         done_q[$];

    ovp_1010_tx #(.CW(8), .GAP_LEN(GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_cnt_in  (i_cnt_in),
        .o_ready   (o_ready),
        .o_busy    (o_busy),
        .o_bit_out (o_bit_out),
        .o_bit_vld (o_bit_vld),
        .o_exp_det (o_exp_det),
        .o_done    (o_done)
`ifdef OVP_TX_STATUS_EN
        ,
        .o_sent_cnt(o_sent_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected bits/done cycles whenever the DUT presents them.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_bit_vld) begin
                chk("ref_detector", int'(o_exp_det), int'({hist, o_bit_out} == 4'b1010));
                hist = {hist[1:0], o_bit_out};
                if (o_exp_det)
                    det_total++;
                if (exp_q.size() == 0)
                    chk("unexpected_bit", 1, 0);
                else
                    chk("bit_and_det", int'({o_bit_out, o_exp_det}), int'(exp_q.pop_front()));
            end else begin
                chk("det_without_vld", int'(o_exp_det), 0);
            end
            if (o_done) begin
                if (done_q.size() == 0)
                    chk("unexpected_done", 1, 0);
                else
                    chk("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    task automatic push_bits(input int len, input logic [31:0] bits, input logic [31:0] exps);
        for (int i = len - 1; i >= 0; i--)
            exp_q.push_back({bits[i], exps[i]});
    endtask

    // Drives start in the current cycle; done is expected relative to this cycle.
    task automatic issue(input int n, input int len, input logic [31:0] bits, input logic [31:0] exps);
        int w = 0;
        while (!o_ready && w < 50) begin
            tick();
            w++;
        end
        chk("ready_before_start", int'(o_ready), 1);
        push_bits(len, bits, exps);
        done_q.push_back(cyc + ((n == 0) ? 1 : 2 * n + 2 + GAP + 1));
        i_start  = 1'b1;
        i_cnt_in = 8'(n);
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        chk("drain_timeout", exp_q.size() + done_q.size(), 0);
        tick();
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk(nm, int'({o_ready, o_busy, o_bit_out, o_bit_vld, o_exp_det, o_done}), int'(6'b100000));
    endtask

    initial begin
        int c;
        repeat (3) tick();
        chk_reset_outputs("reset_values");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_no_vld", int'(o_bit_vld), 0);
        end

        issue(1, 6, 32'b101000, 32'b000100);
        wait_idle();

        issue(3, 10, 32'b1010101000, 32'b0001010100);
        wait_idle();

        issue(0, 0, 32'b0, 32'b0);
        chk("n0_not_ready_k1", int'(o_ready), 0);
        tick();
        chk("n0_ready_k2", int'(o_ready), 1);
        wait_idle();

        // Reset while the 4th bit is on the wire abandons the burst.
        c = cyc;
        issue(5, 14, 32'b10101010101000, 32'b00010101010100);
        while (cyc < c + 4)
            tick();
        rst = 1'b1;
        tick();
        chk_reset_outputs("midburst_reset");
        exp_q.delete();
        done_q.delete();
        hist = 3'b000;
        det_total = 0;
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("no_done_after_abort", int'(o_done), 0);
        end
        issue(1, 6, 32'b101000, 32'b000100);
        wait_idle();

        // start pulses while busy must not alter the running burst.
        c = cyc;
        issue(2, 8, 32'b10101000, 32'b00010100);
        while (cyc < c + 2)
            tick();
        i_cnt_in = 8'd7;
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
        tick();
        tick();
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
        wait_idle();

        // start held high: second burst accepted on the single IDLE cycle.
        c = cyc;
        push_bits(6, 32'b101000, 32'b000100);
        push_bits(6, 32'b101000, 32'b000100);
        done_q.push_back(c + 7);
        done_q.push_back(c + 15);
        i_cnt_in = 8'd1;
        i_start  = 1'b1;
        while (cyc < c + 9)
            tick();
        i_start = 1'b0;
        wait_idle();

        repeat (3) tick();
`ifdef OVP_TX_STATUS_EN
        chk("sent_cnt", int'(o_sent_cnt), det_total);
`endif
        chk("final_idle_ready", int'(o_ready), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
